// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: walks the anodes with a blanking gap per slot
// and takes new display content only at frame boundaries through a load/ack handshake.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] val_q, val_d;
    logic [3:0]  dpr_q, dpr_d;
    logic [3:0]  en_q, en_d;

    logic        an_unused;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        load_ack_q, load_ack_d;
    logic        frame_tick_q, frame_tick_d;

    logic        wrap;
    logic        capture;

    // Outputs are registered from the next-state values, so in every cycle they
    // match the counter/index/shadow contents held in that same cycle.
    always_comb begin
        wrap    = (cnt_q == CNT_MAX);
        capture = wrap && (idx_q == 2'd3) && load;

        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;

        state_d = state_q;
        if (wrap) begin
            state_d = ST_BLANK;
        end else if (cnt_d == CNT_SHOW) begin
            state_d = ST_SHOW;
        end

        val_d = capture ? value    : val_q;
        dpr_d = capture ? dp_in    : dpr_q;
        en_d  = capture ? digit_en : en_q;

        nibble_d = 4'h0;
        case (idx_d)
            2'd0:    nibble_d = val_d[3:0];
            2'd1:    nibble_d = val_d[7:4];
            2'd2:    nibble_d = val_d[11:8];
            default: nibble_d = val_d[15:12];
        endcase

        an_d = 4'b1111;
        dp_d = 1'b1;
        if (state_d == ST_SHOW) begin
            an_d[idx_d] = ~en_d[idx_d];
            dp_d        = ~dpr_d[idx_d];
        end

        load_ack_d   = capture;
        frame_tick_d = (idx_d == 2'd3) && (cnt_d == CNT_MAX);
        an_unused    = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            val_q        <= 16'h0000;
            dpr_q        <= 4'h0;
            en_q         <= 4'h0;
            an_q         <= 4'b1111;
            dp_q         <= 1'b1;
            nibble_q     <= 4'h0;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            val_q        <= val_d;
            dpr_q        <= dpr_d;
            en_q         <= en_d;
            an_q         <= an_d | {4{an_unused}};
            dp_q         <= dp_d;
            nibble_q     <= nibble_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign dp         = dp_q;
    assign nibble     = nibble_q;
    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with an 8-cycle slot and a 2-cycle blank.
module tb_seg_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        load = 1'b0;
    logic        load_ack;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_en = 4'h0;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .load_ack(load_ack),
        .nibble(nibble), .an(an), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [3:0] e_an(input int c);
        logic [3:0] r;
        r = 4'b1111;
        if ((c % RD) >= BC) r[(c / RD) % 4] = ~m_en[(c / RD) % 4];
        return r;
    endfunction

    function automatic logic e_dp(input int c);
        if ((c % RD) < BC) return 1'b1;
        return ~m_dp[(c / RD) % 4];
    endfunction

    function automatic logic [3:0] e_nib(input int c);
        logic [15:0] v;
        v = m_val >> (4 * ((c / RD) % 4));
        return v[3:0];
    endfunction

    task automatic check_cycle();
        chk("an", {12'h0, an}, {12'h0, e_an(cyc)});
        chk("dp", {15'h0, dp}, {15'h0, e_dp(cyc)});
        chk("nibble", {12'h0, nibble}, {12'h0, e_nib(cyc)});
        chk("frame_tick", {15'h0, frame_tick}, {15'h0, ((cyc % (4 * RD)) == (4 * RD - 1))});
        chk("an_onehot", {15'h0, ($countones(~an) <= 1)}, 16'h0001);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc   = 0;
        m_val = 16'h0000;
        m_dp  = 4'h0;
        m_en  = 4'h0;
    endtask

    initial begin
        // 1: reset, no load -> dark display, frame_tick at 31 and 63
        value = 16'h1234; dp_in = 4'hF; digit_en = 4'hF;
        do_reset();
        while (cyc <= 63) begin
            check_cycle();
            chk("t1_ack", {15'h0, load_ack}, 16'h0000);
            if (cyc == 31 || cyc == 63) chk("t1_tick", {15'h0, frame_tick}, 16'h0001);
            tick();
        end

        // 2: load at cycle 5, ack at 32, then digit walk
        value = 16'h1A3F; dp_in = 4'b0100; digit_en = 4'b1111;
        do_reset();
        while (cyc <= 63) begin
            if (cyc == 32) begin
                m_val = 16'h1A3F; m_dp = 4'b0100; m_en = 4'b1111;
            end
            check_cycle();
            chk("t2_ack", {15'h0, load_ack}, {15'h0, (cyc == 32)});
            if (cyc == 33) chk("t2_blank33", {12'h0, an}, 16'h000F);
            if (cyc == 34) chk("t2_d0", {8'h0, an, nibble, 3'b0, dp}, 16'h00EF1);
            if (cyc == 42) chk("t2_d1", {8'h0, an, nibble}, 16'h00D3);
            if (cyc == 50) chk("t2_d2", {8'h0, an, nibble, 3'b0, dp}, 16'h0BA0);
            if (cyc == 58) chk("t2_d3", {8'h0, an, nibble}, 16'h0071);
            if (cyc == 5) load = 1'b1;
            if (cyc == 32) load = 1'b0;
            tick();
        end

        // 3: digits 1 and 3 disabled, one-low checked over 256 cycles
        value = 16'h4321; dp_in = 4'b0000; digit_en = 4'b0101;
        do_reset();
        load = 1'b1;
        while (cyc <= 255) begin
            if (cyc == 32) begin
                m_val = 16'h4321; m_dp = 4'b0000; m_en = 4'b0101;
            end
            check_cycle();
            chk("t3_ack", {15'h0, load_ack}, {15'h0, (cyc == 32)});
            if (cyc == 42 || cyc == 58) chk("t3_dark", {12'h0, an}, 16'h000F);
            if (cyc == 50) chk("t3_d2", {8'h0, an, nibble}, 16'h00B3);
            if (cyc == 32) load = 1'b0;
            tick();
        end

        // 4a: value changes without load never reach the display
        value = 16'h4321; dp_in = 4'b0000; digit_en = 4'b1111;
        do_reset();
        load = 1'b1;
        while (cyc <= 127) begin
            if (cyc == 32) begin
                m_val = 16'h4321; m_dp = 4'b0000; m_en = 4'b1111;
            end
            check_cycle();
            chk("t4a_ack", {15'h0, load_ack}, {15'h0, (cyc == 32)});
            if (cyc == 98)  chk("t4a_n0", {12'h0, nibble}, 16'h0001);
            if (cyc == 106) chk("t4a_n1", {12'h0, nibble}, 16'h0002);
            if (cyc == 114) chk("t4a_n2", {12'h0, nibble}, 16'h0003);
            if (cyc == 122) chk("t4a_n3", {12'h0, nibble}, 16'h0004);
            if (cyc == 32) load = 1'b0;
            if (cyc == 40) value = 16'hFFFF;
            tick();
        end

        // 4b: load held across two boundaries -> acks at 32 and 64
        value = 16'h4321; dp_in = 4'b0000; digit_en = 4'b1111;
        do_reset();
        load = 1'b1;
        while (cyc <= 100) begin
            if (cyc == 32) begin
                m_val = 16'h4321; m_dp = 4'b0000; m_en = 4'b1111;
            end
            check_cycle();
            chk("t4b_ack", {15'h0, load_ack}, {15'h0, (cyc == 32 || cyc == 64)});
            if (cyc == 64) load = 1'b0;
            tick();
        end

        // 5: asynchronous reset inside digit 1 SHOW
        value = 16'h1A3F; dp_in = 4'b0100; digit_en = 4'b1111;
        do_reset();
        load = 1'b1;
        while (cyc <= 45) begin
            if (cyc == 32) begin
                m_val = 16'h1A3F; m_dp = 4'b0100; m_en = 4'b1111;
            end
            check_cycle();
            chk("t5_ack", {15'h0, load_ack}, {15'h0, (cyc == 32)});
            if (cyc == 45) chk("t5_pre", {12'h0, an}, 16'h000D);
            if (cyc == 32) load = 1'b0;
            if (cyc < 45) tick();
            else break;
        end
        load  = 1'b1;
        value = 16'h5555;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_an", {12'h0, an}, 16'h000F);
        chk("t5_async_dp", {15'h0, dp}, 16'h0001);
        chk("t5_async_nib", {12'h0, nibble}, 16'h0000);
        chk("t5_async_ack", {15'h0, load_ack}, 16'h0000);
        load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_hold_an", {12'h0, an}, 16'h000F);
        chk("t5_hold_ack", {15'h0, load_ack}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc = 0;
        m_val = 16'h0000; m_dp = 4'h0; m_en = 4'h0;
        while (cyc <= 63) begin
            check_cycle();
            chk("t5_post_ack", {15'h0, load_ack}, 16'h0000);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
